lc3b_mem_responder: RTL and testbench

//  Memory-side end of the LC-3b datapath memory interface: services mem_read/mem_write

---
 rtl/lc3b_mem_responder.sv | 111 +++++++++++
 tb/tb_lc3b_mem_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_mem_responder.sv
// Memory-side responder for the LC-3b memory interface: fixed-latency word RAM with
// byte-lane writes, a registered read-data port and a one-cycle mem_resp completion pulse.
module lc3b_mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_resp
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [7:0] COUNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                 state_reg, state_next;
  logic [7:0]             count_reg, count_next;
  logic                   op_write_reg, op_write_next;
  logic [ADDR_BITS-1:0]   idx_reg, idx_next;
  logic [1:0]             wmask_reg, wmask_next;
  logic [15:0]            wdata_reg, wdata_next;
  logic [15:0]            rdata_reg;
  logic [15:0]            ram_word;
  logic                   complete;
  logic                   addr_unused;

  // Byte 0 and the bits above the word index never select storage.
  assign addr_unused = ^mem_address;

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    op_write_next = op_write_reg;
    idx_next      = idx_reg;
    wmask_next    = wmask_reg;
    wdata_next    = wdata_reg;
    complete      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_read || mem_write) begin
          state_next    = BUSY;
          count_next    = COUNT_INIT;
          op_write_next = mem_write;   // write wins when both are requested
          idx_next      = mem_address[ADDR_BITS:1];
          wmask_next    = mem_byte_enable;
          wdata_next    = mem_wdata;
        end
      end
      BUSY: begin
        if (!(mem_read || mem_write)) begin
          state_next = IDLE;
        end else if (count_reg != 8'd0) begin
          count_next = count_reg - 8'd1;
        end else begin
          state_next = RESP;
          complete   = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_reg    <= 8'd0;
      op_write_reg <= 1'b0;
      idx_reg      <= '0;
      wmask_reg    <= 2'b00;
      wdata_reg    <= 16'h0000;
      rdata_reg    <= 16'h0000;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      op_write_reg <= op_write_next;
      idx_reg      <= idx_next;
      wmask_reg    <= wmask_next;
      wdata_reg    <= wdata_next;
      if (complete && !op_write_reg) begin
        rdata_reg <= ram_word;
      end
    end
  end

  // One independent byte-wide array per lane so each lane's write enable stays separate.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (complete && op_write_reg && wmask_reg[gi]) begin
          lane_mem[idx_reg] <= wdata_reg[gi*8 +: 8];
        end
      end

      assign ram_word[gi*8 +: 8] = lane_mem[idx_reg];
    end
  endgenerate

  assign mem_rdata = rdata_reg;
  assign mem_resp  = (state_reg == RESP);

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Self-checking bench for lc3b_mem_responder: directed scenarios plus randomized
// traffic checked against a word-array reference model.
module tb_lc3b_mem_responder;

  localparam int AB = 8;
  localparam int L  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  mem_byte_enable = 2'b00;
  logic [15:0] mem_address = 16'h0000;
  logic [15:0] mem_wdata = 16'h0000;
  logic [15:0] mem_rdata;
  logic        mem_resp;

  int checks = 0;
  int passes = 0;

  logic [15:0] model [256];
  logic [15:0] exp_rdata = 16'h0000;

  lc3b_mem_responder #(.ADDR_BITS(AB), .LATENCY(L)) dut (
    .clk(clk),
    .reset(reset),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  function automatic int widx(input logic [15:0] addr);
    return (int'(addr) / 2) % 256;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] data,
                                        input logic [1:0] mask);
    logic [15:0] m;
    m = {{8{mask[1]}}, {8{mask[0]}}};
    return (old & ~m) | (data & m);
  endfunction

  // Drives one request, scrambles the payload inputs while busy, and reports what it saw.
  task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] data, input logic [1:0] mask,
                        output int lat, output logic [15:0] rdata, output logic resp_after);
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = data; mem_byte_enable = mask;
    lat = -1;
    rdata = 16'hxxxx;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (mem_resp) begin
        lat = n - 1;
        rdata = mem_rdata;
        break;
      end
      if (n == 1) begin
        mem_address = 16'($urandom);
        mem_wdata = 16'($urandom);
        mem_byte_enable = 2'($urandom);
      end
    end
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    resp_after = mem_resp;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_resp !== 1'b0) $display("FAIL reset_resp got=%b exp=0", mem_resp); else passes++;
    checks++; if (mem_rdata !== 16'h0000) $display("FAIL reset_rdata got=%h exp=0000", mem_rdata); else passes++;
    @(negedge clk);
    reset = 1'b0;
    exp_rdata = 16'h0000;
  endtask

  task automatic test_write_read();
    int lat; logic [15:0] rd; logic ra;
    access(1'b0, 1'b1, 16'h0040, 16'hBEEF, 2'b11, lat, rd, ra);
    model[widx(16'h0040)] = 16'hBEEF;
    $display("write 0040 BEEF lat=%0d", lat);
    checks++; if (lat != L) $display("FAIL wr_latency got=%0d exp=%0d", lat, L); else passes++;
    checks++; if (ra !== 1'b0) $display("FAIL wr_resp_width got=%b exp=0", ra); else passes++;
    checks++; if (rd !== exp_rdata) $display("FAIL wr_rdata_held got=%h exp=%h", rd, exp_rdata); else passes++;
    access(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, lat, rd, ra);
    exp_rdata = model[widx(16'h0040)];
    $display("read 0040 -> %h lat=%0d", rd, lat);
    checks++; if (lat != L) $display("FAIL rd_latency got=%0d exp=%0d", lat, L); else passes++;
    checks++; if (rd !== 16'hBEEF) $display("FAIL rd_data got=%h exp=BEEF", rd); else passes++;
    checks++; if (ra !== 1'b0) $display("FAIL rd_resp_width got=%b exp=0", ra); else passes++;
  endtask

  task automatic test_byte_lanes();
    int lat; logic [15:0] rd; logic ra;
    logic [1:0] masks [4];
    masks[0] = 2'b11; masks[1] = 2'b01; masks[2] = 2'b10; masks[3] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] d;
      d = (i == 0) ? 16'h1234 : 16'hABCD;
      access(1'b0, 1'b1, 16'h0020, d, masks[i], lat, rd, ra);
      model[widx(16'h0020)] = merge(model[widx(16'h0020)], d, masks[i]);
      checks++; if (lat != L) $display("FAIL lane_wr_latency mask=%b got=%0d exp=%0d", masks[i], lat, L); else passes++;
      access(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, lat, rd, ra);
      exp_rdata = model[widx(16'h0020)];
      $display("lane mask=%b data=%h read -> %h", masks[i], d, rd);
      checks++; if (rd !== exp_rdata) $display("FAIL lane_read mask=%b got=%h exp=%h", masks[i], rd, exp_rdata); else passes++;
    end
    checks++; if (exp_rdata !== 16'hABCD) $display("FAIL lane_final got=%h exp=ABCD", exp_rdata); else passes++;
  endtask

  task automatic test_reset_busy();
    int lat; logic [15:0] rd; logic ra; int bad;
    access(1'b0, 1'b1, 16'h0010, 16'h1111, 2'b11, lat, rd, ra);
    model[widx(16'h0010)] = 16'h1111;
    @(negedge clk);
    mem_write = 1'b1; mem_address = 16'h0010; mem_wdata = 16'h2222; mem_byte_enable = 2'b11;
    @(posedge clk); #2;
    reset = 1'b1; mem_write = 1'b0;
    bad = 0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (mem_resp !== 1'b0 || mem_rdata !== 16'h0000) bad++;
    end
    checks++; if (bad != 0) $display("FAIL reset_busy_outputs got=%0d_bad_cycles exp=0", bad); else passes++;
    @(negedge clk);
    reset = 1'b0;
    exp_rdata = 16'h0000;
    access(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, lat, rd, ra);
    exp_rdata = model[widx(16'h0010)];
    $display("read after reset-abort 0010 -> %h", rd);
    checks++; if (rd !== 16'h1111) $display("FAIL reset_busy_data got=%h exp=1111", rd); else passes++;
  endtask

  task automatic test_abort();
    int lat; logic [15:0] rd; logic ra;
    @(negedge clk);
    mem_read = 1'b1; mem_address = 16'h0040;
    @(posedge clk);
    @(negedge clk);
    mem_read = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_resp !== 1'b0) $display("FAIL abort_resp got=%b exp=0", mem_resp); else passes++;
    access(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, lat, rd, ra);
    exp_rdata = model[widx(16'h0040)];
    $display("read after abort 0040 -> %h lat=%0d", rd, lat);
    checks++; if (lat != L) $display("FAIL abort_next_latency got=%0d exp=%0d", lat, L); else passes++;
    checks++; if (rd !== exp_rdata) $display("FAIL abort_next_data got=%h exp=%h", rd, exp_rdata); else passes++;
  endtask

  task automatic test_back_to_back();
    int first, second, total; logic prev, consec; int bad_data;
    first = -1; second = -1; total = 0; prev = 1'b0; consec = 1'b0; bad_data = 0;
    @(negedge clk);
    mem_read = 1'b1; mem_address = 16'h0020;
    for (int n = 1; n <= 2 * L + 8; n++) begin
      @(posedge clk); #1;
      if (mem_resp) begin
        total++;
        if (prev) consec = 1'b1;
        if (mem_rdata !== model[widx(16'h0020)]) bad_data++;
        if (first < 0) first = n;
        else if (second < 0) begin
          second = n;
          mem_read = 1'b0;
        end
      end
      prev = mem_resp;
    end
    mem_read = 1'b0;
    exp_rdata = model[widx(16'h0020)];
    $display("held read resp cycles %0d and %0d", first, second);
    checks++; if (first != L + 1) $display("FAIL held_first got=%0d exp=%0d", first, L + 1); else passes++;
    checks++; if (second != 2 * L + 3) $display("FAIL held_second got=%0d exp=%0d", second, 2 * L + 3); else passes++;
    checks++; if (total != 2 || consec) $display("FAIL held_pulses got=%0d consec=%b exp=2 consec=0", total, consec); else passes++;
    checks++; if (bad_data != 0) $display("FAIL held_data got=%0d_bad exp=0", bad_data); else passes++;
  endtask

  task automatic test_wrap_and_both();
    int lat; logic [15:0] rd; logic ra;
    access(1'b0, 1'b1, 16'h0202, 16'h5A5A, 2'b11, lat, rd, ra);
    model[widx(16'h0202)] = 16'h5A5A;
    access(1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, lat, rd, ra);
    exp_rdata = model[widx(16'h0002)];
    $display("wrap read 0002 -> %h", rd);
    checks++; if (rd !== 16'h5A5A) $display("FAIL wrap_data got=%h exp=5A5A", rd); else passes++;
    access(1'b1, 1'b1, 16'h0002, 16'h1357, 2'b11, lat, rd, ra);
    model[widx(16'h0002)] = 16'h1357;
    $display("read+write 0002 1357 rdata=%h", rd);
    checks++; if (rd !== exp_rdata) $display("FAIL both_rdata got=%h exp=%h", rd, exp_rdata); else passes++;
    checks++; if (lat != L) $display("FAIL both_latency got=%0d exp=%0d", lat, L); else passes++;
    access(1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, lat, rd, ra);
    exp_rdata = model[widx(16'h0002)];
    checks++; if (rd !== 16'h1357) $display("FAIL both_written got=%h exp=1357", rd); else passes++;
  endtask

  task automatic test_random();
    int lat; logic [15:0] rd; logic ra;
    logic [15:0] addr, data; logic [1:0] mask; int op; logic [7:0] wi;
    for (int i = 0; i < 8; i++) begin
      wi = 8'(8'h80 + i);
      addr = {7'($urandom), wi, 1'($urandom)};
      data = 16'($urandom);
      access(1'b0, 1'b1, addr, data, 2'b11, lat, rd, ra);
      model[widx(addr)] = data;
    end
    for (int i = 0; i < 24; i++) begin
      wi = 8'(8'h80 + $urandom_range(0, 7));
      addr = {7'($urandom), wi, 1'($urandom)};
      data = 16'($urandom);
      mask = 2'($urandom);
      op = $urandom_range(0, 2);
      access(op != 1, op != 0, addr, data, mask, lat, rd, ra);
      if (op == 0) exp_rdata = model[widx(addr)];
      else model[widx(addr)] = merge(model[widx(addr)], data, mask);
      $display("rand op=%0d addr=%h data=%h mask=%b rdata=%h lat=%0d", op, addr, data, mask, rd, lat);
      checks++; if (lat != L || ra !== 1'b0) $display("FAIL rand_timing i=%0d got=%0d/%b exp=%0d/0", i, lat, ra, L); else passes++;
      checks++; if (rd !== exp_rdata) $display("FAIL rand_rdata i=%0d got=%h exp=%h", i, rd, exp_rdata); else passes++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_reset_busy();
    test_abort();
    test_back_to_back();
    test_wrap_and_both();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
